// File: rtl/id_ex_skid_stage.sv
// ID->EX pipeline register: 2-entry skid buffer (main + skid) carrying instr, link address and NUM_CH operands.
// Latency: 1 cycle from accept to out_*; full throughput when out_ready stays high.
// Backpressure: in_ready is registered (low only when both entries are held); flush empties the stage.
module id_ex_skid_stage #(
    parameter int          NUM_CH    = 3,
    parameter int          DATA_W    = 32,
    parameter int          PC_W      = 32,
    parameter int          LINK_OFF  = 4,
    parameter logic [31:0] NOP_INSTR = 32'h0,
    parameter int          CNT_W     = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_instr,
    input  logic [PC_W-1:0]          in_pc_plus4,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_instr,
    output logic [PC_W-1:0]          out_pc_plus8,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic [1:0]               occupancy,
    output logic [CNT_W-1:0]         bubble_cnt
);

    localparam int DW = NUM_CH * DATA_W;

    // State encoding doubles as the entry count.
    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_TWO   = 2'd2;

    logic [1:0]      state;
    logic [1:0]      state_nxt;
    logic            accept;
    logic            consume;
    logic            main_from_in;
    logic            main_from_skid;
    logic            skid_from_in;
    logic [PC_W-1:0] in_link;

    logic [31:0]     main_instr;
    logic [PC_W-1:0] main_link;
    logic [DW-1:0]   main_data;
    logic [31:0]     skid_instr;
    logic [PC_W-1:0] skid_link;
    logic [DW-1:0]   skid_data;

    assign accept    = in_valid & in_ready;
    assign consume   = out_valid & out_ready;
    assign out_valid = (state != S_EMPTY);
    assign occupancy = state;

    // Link address is formed once at capture so the output path is a plain register.
    assign in_link = in_pc_plus4 + PC_W'(LINK_OFF);

    // Bubble values are forced whenever main does not hold a live entry, so stale payload never leaks.
    assign out_instr    = out_valid ? main_instr : NOP_INSTR;
    assign out_pc_plus8 = out_valid ? main_link  : '0;
    assign out_data     = out_valid ? main_data  : '0;

    // Next-state and entry-load decisions; flush overrides any same-cycle accept/consume.
    always_comb begin
        state_nxt      = state;
        main_from_in   = 1'b0;
        main_from_skid = 1'b0;
        skid_from_in   = 1'b0;
        if (flush) begin
            state_nxt = S_EMPTY;
        end else begin
            case (state)
                S_EMPTY: begin
                    if (accept) begin
                        state_nxt    = S_ONE;
                        main_from_in = 1'b1;
                    end
                end
                S_ONE: begin
                    if (accept && consume) begin
                        main_from_in = 1'b1;
                    end else if (accept) begin
                        state_nxt    = S_TWO;
                        skid_from_in = 1'b1;
                    end else if (consume) begin
                        state_nxt = S_EMPTY;
                    end
                end
                S_TWO: begin
                    if (consume) begin
                        state_nxt      = S_ONE;
                        main_from_skid = 1'b1;
                    end
                end
                default: state_nxt = S_EMPTY;
            endcase
        end
    end

    // Control state; in_ready is registered from the next occupancy so it never sees out_ready combinationally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_EMPTY;
            in_ready <= 1'b1;
        end else begin
            state    <= state_nxt;
            in_ready <= (state_nxt != S_TWO);
        end
    end

    // Entry storage: main is the output entry, skid holds the overflow entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_instr <= NOP_INSTR;
            main_link  <= '0;
            main_data  <= '0;
            skid_instr <= NOP_INSTR;
            skid_link  <= '0;
            skid_data  <= '0;
        end else begin
            if (main_from_in) begin
                main_instr <= in_instr;
                main_link  <= in_link;
                main_data  <= in_data;
            end else if (main_from_skid) begin
                main_instr <= skid_instr;
                main_link  <= skid_link;
                main_data  <= skid_data;
            end
            if (skid_from_in) begin
                skid_instr <= in_instr;
                skid_link  <= in_link;
                skid_data  <= in_data;
            end
        end
    end

    // Saturating count of cycles where EX was ready but had nothing to execute.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bubble_cnt <= '0;
        end else if (!out_valid && out_ready && (bubble_cnt != {CNT_W{1'b1}})) begin
            bubble_cnt <= bubble_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_id_ex_skid_stage.sv
// Bench for id_ex_skid_stage (NUM_CH=4, CNT_W=4): directed scenarios plus random traffic.
// Reference model is a FIFO queue of expected entries with capacity 2.
// Outputs are checked 1 time unit after each rising edge.
module tb_id_ex_skid_stage;

    localparam int NUM_CH = 4;
    localparam int DATA_W = 32;
    localparam int PC_W   = 32;
    localparam int CNT_W  = 4;
    localparam int DW     = NUM_CH * DATA_W;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_instr;
    logic [31:0]   in_pc_plus4;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_instr;
    logic [31:0]   out_pc_plus8;
    logic [DW-1:0] out_data;
    logic [1:0]    occupancy;
    logic [CNT_W-1:0] bubble_cnt;

    id_ex_skid_stage #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .PC_W(PC_W), .LINK_OFF(4),
        .NOP_INSTR(32'h0), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_pc_plus4(in_pc_plus4), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc_plus8(out_pc_plus8), .out_data(out_data),
        .occupancy(occupancy), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0]   instr;
        logic [31:0]   link;
        logic [DW-1:0] data;
    } entry_t;

    entry_t q[$];
    int     bcnt;
    int     total  = 0;
    int     passed = 0;
    int     failed = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare every output against the model's view of the stage.
    task automatic check_all(input string tag);
        entry_t e;
        e = '0;
        if (q.size() > 0) e = q[0];
        chk({tag, ".out_valid"}, DW'(out_valid), DW'(q.size() > 0));
        chk({tag, ".out_instr"}, DW'(out_instr), DW'(e.instr));
        chk({tag, ".out_pc_plus8"}, DW'(out_pc_plus8), DW'(e.link));
        chk({tag, ".out_data"}, out_data, e.data);
        chk({tag, ".occupancy"}, DW'(occupancy), DW'(q.size()));
        chk({tag, ".in_ready"}, DW'(in_ready), DW'(q.size() != 2));
        chk({tag, ".bubble_cnt"}, DW'(bubble_cnt), DW'(bcnt));
    endtask

    // One clock cycle: drive inputs, advance the model, check after the edge.
    task automatic step(input string tag, input logic v, input logic [31:0] ins,
                        input logic [31:0] pc, input logic [DW-1:0] d,
                        input logic ordy, input logic fl);
        bit     acc;
        bit     con;
        entry_t e;
        in_valid    = v;
        in_instr    = ins;
        in_pc_plus4 = pc;
        in_data     = d;
        out_ready   = ordy;
        flush       = fl;
        acc = v && (q.size() < 2);
        con = ordy && (q.size() > 0);
        if (q.size() == 0 && ordy && bcnt < (1 << CNT_W) - 1) bcnt++;
        e.instr = ins;
        e.link  = pc + 32'd4;
        e.data  = d;
        @(posedge clk);
        #1;
        if (fl) begin
            q.delete();
        end else begin
            if (con) void'(q.pop_front());
            if (acc) q.push_back(e);
        end
        check_all(tag);
    endtask

    function automatic logic [DW-1:0] rnd_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [DW-1:0] d;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_pc_plus4 = '0; in_data = '0;
        bcnt = 0;
        #12;
        check_all("reset");
        @(posedge clk); #1;
        reset = 1'b0;
        check_all("post_reset");

        // 1: stream 8 entries with both sides always ready.
        step("stream_prime", 1'b1, 32'h1000_0000, 32'h0040_0004, rnd_data(), 1'b0, 1'b0);
        for (int i = 1; i < 8; i++)
            step("stream", 1'b1, 32'h1000_0000 + 32'(i), 32'h0040_0004 + 32'(4*i), rnd_data(), 1'b1, 1'b0);
        step("stream_drain", 1'b0, '0, '0, '0, 1'b1, 1'b0);
        step("stream_idle", 1'b0, '0, '0, '0, 1'b0, 1'b0);

        // 2: hold out_ready low while offering A, B, C; C must be refused.
        step("bp_A", 1'b1, 32'hAAAA_0001, 32'h0000_1004, rnd_data(), 1'b0, 1'b0);
        step("bp_B", 1'b1, 32'hBBBB_0002, 32'h0000_1008, rnd_data(), 1'b0, 1'b0);
        step("bp_C_refused", 1'b1, 32'hCCCC_0003, 32'h0000_100C, rnd_data(), 1'b0, 1'b0);
        chk("bp_full_occ", DW'(occupancy), DW'(2));
        chk("bp_full_rdy", DW'(in_ready), DW'(0));
        step("bp_out_A", 1'b1, 32'hCCCC_0003, 32'h0000_100C, rnd_data(), 1'b1, 1'b0);
        step("bp_out_B", 1'b0, '0, '0, '0, 1'b1, 1'b0);
        step("bp_out_C", 1'b0, '0, '0, '0, 1'b1, 1'b0);
        step("bp_empty", 1'b0, '0, '0, '0, 1'b0, 1'b0);

        // 3: flush while full with a valid input present.
        step("fl_A", 1'b1, 32'hF00D_0001, 32'h0000_2004, rnd_data(), 1'b0, 1'b0);
        step("fl_B", 1'b1, 32'hF00D_0002, 32'h0000_2008, rnd_data(), 1'b0, 1'b0);
        step("fl_flush", 1'b1, 32'hDEAD_BEEF, 32'h0000_200C, rnd_data(), 1'b1, 1'b1);
        chk("fl_out_instr_nop", DW'(out_instr), DW'(32'h0));
        chk("fl_in_ready", DW'(in_ready), DW'(1));
        step("fl_after", 1'b0, '0, '0, '0, 1'b1, 1'b0);

        // 4: link address wraps; channels carried in place.
        d = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        step("wrap", 1'b1, 32'h0000_0013, 32'hFFFF_FFFC, d, 1'b0, 1'b0);
        chk("wrap_pc8", DW'(out_pc_plus8), DW'(32'h0));
        chk("wrap_ch", out_data, d);
        step("wrap_drain", 1'b0, '0, '0, '0, 1'b1, 1'b0);

        // 5: bubble counter saturation, then an asynchronous reset mid-cycle.
        for (int i = 0; i < 20; i++)
            step("sat", 1'b0, '0, '0, '0, 1'b1, 1'b0);
        chk("sat_value", DW'(bubble_cnt), DW'(15));
        step("pre_rst_A", 1'b1, 32'h0BAD_0001, 32'h0000_3004, rnd_data(), 1'b0, 1'b0);
        step("pre_rst_B", 1'b1, 32'h0BAD_0002, 32'h0000_3008, rnd_data(), 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        q.delete();
        bcnt = 0;
        check_all("async_rst");
        @(posedge clk); #1;
        reset = 1'b0;
        check_all("async_rst_release");

        // Random traffic with occasional flushes.
        for (int i = 0; i < 400; i++)
            step("rand", 1'($urandom_range(0, 3) != 0), $urandom, $urandom, rnd_data(),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
